// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state/op encodings and parameter defaults
package mem_responder_pkg;
  localparam int DEPTH_DEF = 256;
  localparam int LATENCY_DEF = 2;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE64, OP_WRITE32} op_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: initiator-to-responder memory request bus
interface mem_responder_if;
  logic [63:0] adr;
  logic [63:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        sw;
  logic [63:0] rdata;
  logic        ready;
  logic        busy;
  logic        adr_err;
  modport master (output adr, wdata, mem_read, mem_write, sw, input rdata, ready, busy, adr_err);
  modport slave (input adr, wdata, mem_read, mem_write, sw, output rdata, ready, busy, adr_err);
endinterface

// File: rtl/mem_array_64b.sv
// mem_array_64b: doubleword storage with per-half write enables and combinational read
module mem_array_64b
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];
  // halves are written independently so a word store leaves its neighbour intact
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][31:0] <= wdata[31:0];
    if (we[1]) mem[addr][63:32] <= wdata[63:32];
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder with alignment and range checking
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input logic clk,
  input logic rst,
  mem_responder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  state_t state, state_n;
  op_t op;
  logic [63:0] adr_q, wdata_q, rdata_q, rd, rd_out, wd;
  logic [3:0] cnt, cnt_n;
  logic req, err, rd_done;
  logic [1:0] we;
  assign req = bus.mem_read || bus.mem_write;
  assign err = (op == OP_WRITE32 ? |adr_q[1:0] : |adr_q[2:0]) || (adr_q >= 64'(DEPTH) * 64'd8);
  assign rd_done = (state == DONE) && (op == OP_READ);
  assign rd_out = err ? '0 : rd;
  assign wd = (op == OP_WRITE32) ? {2{wdata_q[31:0]}} : wdata_q;
  assign we = (state == DONE && !err && !rst && op != OP_READ) ?
              (op == OP_WRITE64 ? 2'b11 : (adr_q[2] ? 2'b10 : 2'b01)) : 2'b00;
  assign bus.ready = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.adr_err = (state == DONE) && err;
  assign bus.rdata = rd_done ? rd_out : rdata_q;
  // state, latency counter and held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (rd_done) rdata_q <= rd_out;
    end
  end
  // capture the request at accept; a write wins over a simultaneous read
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      adr_q <= bus.adr;
      wdata_q <= bus.wdata;
      op <= bus.mem_write ? (bus.sw ? OP_WRITE32 : OP_WRITE64) : OP_READ;
    end
  end
  // next-state and counter; LATENCY of 1 skips the wait state entirely
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (req) begin
        state_n = (LATENCY == 1) ? DONE : WAIT;
        cnt_n = CNT_LOAD;
      end
      WAIT: begin
        state_n = (cnt == 0) ? DONE : WAIT;
        cnt_n = (cnt == 0) ? cnt : cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  mem_array_64b #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk),
    .we(we),
    .addr(adr_q[3 +: AW]),
    .wdata(wd),
    .rdata(rd)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table-driven checks of mem_responder
module tb_mem_responder;
  typedef struct {
    logic rd, wr, sw;
    logic [63:0] adr, wdata, rdata;
    logic err;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int passed = 0;
  vec_t v[17];
  always #5 clk = ~clk;
  mem_responder_if b2();
  mem_responder_if b1();
  mem_responder_if b4();
  mem_responder u2 (.clk(clk), .rst(rst), .bus(b2));
  mem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_responder #(.LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  function automatic vec_t mk(logic rd, logic wr, logic sw, logic [63:0] adr, logic [63:0] wdata,
                              logic [63:0] rdata, logic err);
    vec_t t;
    t.rd = rd; t.wr = wr; t.sw = sw; t.adr = adr; t.wdata = wdata; t.rdata = rdata; t.err = err;
    return t;
  endfunction

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", n, got, exp);
  endtask

  task automatic idle2();
    b2.mem_read = 0; b2.mem_write = 0; b2.sw = 0; b2.adr = 0; b2.wdata = 0;
  endtask

  task automatic idle14();
    b1.mem_read = 0; b1.mem_write = 0; b1.sw = 0; b1.adr = 0; b1.wdata = 0;
    b4.mem_read = 0; b4.mem_write = 0; b4.sw = 0; b4.adr = 0; b4.wdata = 0;
  endtask

  task automatic txn(input vec_t t, input string n, input bit junk,
                     output logic [63:0] rd, output logic er, output int lat);
    @(negedge clk);
    b2.mem_read = t.rd; b2.mem_write = t.wr; b2.sw = t.sw; b2.adr = t.adr; b2.wdata = t.wdata;
    @(posedge clk);
    lat = 0; rd = 'x; er = 'x;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (b2.ready) begin
        lat = k; rd = b2.rdata; er = b2.adr_err;
        idle2();
      end else begin
        if (k == 1) chk($sformatf("%s_busy", n), 64'(b2.busy), 64'd1);
        if (junk) begin
          b2.mem_read = 1; b2.mem_write = 1; b2.sw = 1'($urandom);
          b2.adr = {32'($urandom), 32'($urandom)}; b2.wdata = {32'($urandom), 32'($urandom)};
        end else idle2();
      end
    end
    if (lat == 0) idle2();
  endtask

  task automatic lat_pair(input logic wr, input logic [63:0] adr, input logic [63:0] wdata,
                          output int l1, output int l4, output logic [63:0] r1, output logic [63:0] r4,
                          output int n1, output int n4);
    @(negedge clk);
    b1.mem_read = !wr; b1.mem_write = wr; b1.sw = 0; b1.adr = adr; b1.wdata = wdata;
    b4.mem_read = !wr; b4.mem_write = wr; b4.sw = 0; b4.adr = adr; b4.wdata = wdata;
    @(posedge clk);
    l1 = 0; l4 = 0; n1 = 0; n4 = 0; r1 = 'x; r4 = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) idle14();
      if (b1.ready) begin n1++; if (l1 == 0) begin l1 = k; r1 = b1.rdata; end end
      if (b4.ready) begin n4++; if (l4 == 0) begin l4 = k; r4 = b4.rdata; end end
    end
  endtask

  initial begin
    logic [63:0] rd, r1, r4;
    logic er;
    int lat, l1, l4, n1, n4, cnt;
    v[0]  = mk(0, 1, 0, 64'h0,   64'h1111_2222_3333_4444, 64'h0, 0);
    v[1]  = mk(0, 1, 0, 64'h10,  64'hDEAD_BEEF_0123_4567, 64'h0, 0);
    v[2]  = mk(1, 0, 0, 64'h10,  64'h0,                   64'hDEAD_BEEF_0123_4567, 0);
    v[3]  = mk(0, 1, 1, 64'h14,  64'h0000_0000_CAFE_F00D, 64'hDEAD_BEEF_0123_4567, 0);
    v[4]  = mk(1, 0, 0, 64'h10,  64'h0,                   64'hCAFE_F00D_0123_4567, 0);
    v[5]  = mk(1, 0, 0, 64'h13,  64'h0,                   64'h0, 1);
    v[6]  = mk(1, 0, 0, 64'h800, 64'h0,                   64'h0, 1);
    v[7]  = mk(0, 1, 0, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
    v[8]  = mk(1, 0, 0, 64'h0,   64'h0,                   64'h1111_2222_3333_4444, 0);
    v[9]  = mk(0, 1, 1, 64'h12,  64'h9999_9999,           64'h1111_2222_3333_4444, 1);
    v[10] = mk(0, 1, 1, 64'h10,  64'hAAAA_5555,           64'h1111_2222_3333_4444, 0);
    v[11] = mk(0, 1, 0, 64'h14,  64'h7777,                64'h1111_2222_3333_4444, 1);
    v[12] = mk(1, 0, 0, 64'h10,  64'h0,                   64'hCAFE_F00D_AAAA_5555, 0);
    v[13] = mk(1, 1, 0, 64'h20,  64'h5,                   64'hCAFE_F00D_AAAA_5555, 0);
    v[14] = mk(1, 0, 0, 64'h20,  64'h0,                   64'h5, 0);
    v[15] = mk(0, 1, 0, 64'h7F8, 64'h0123,                64'h5, 0);
    v[16] = mk(1, 0, 0, 64'h7F8, 64'h0,                   64'h0123, 0);
    idle2();
    idle14();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_ready", 64'(b2.ready), 64'd0);
    chk("rst_busy", 64'(b2.busy), 64'd0);
    chk("rst_err", 64'(b2.adr_err), 64'd0);
    chk("rst_rdata", b2.rdata, 64'd0);
    for (int i = 0; i < 17; i++) begin
      txn(v[i], $sformatf("v%0d", i), 1, rd, er, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd2);
      chk($sformatf("v%0d_rdata", i), rd, v[i].rdata);
      chk($sformatf("v%0d_err", i), 64'(er), 64'(v[i].err));
      @(negedge clk);
      chk($sformatf("v%0d_ready_off", i), 64'(b2.ready), 64'd0);
      chk($sformatf("v%0d_busy_off", i), 64'(b2.busy), 64'd0);
    end
    @(negedge clk);
    b2.mem_write = 1; b2.adr = 64'h10; b2.wdata = 64'h0BAD;
    @(posedge clk);
    @(negedge clk);
    idle2();
    chk("abort_busy_wait", 64'(b2.busy), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 64'(b2.busy), 64'd0);
    chk("abort_rdata", b2.rdata, 64'd0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (b2.ready) cnt++;
      @(negedge clk);
    end
    chk("abort_no_ready", 64'(cnt), 64'd0);
    txn(mk(1, 0, 0, 64'h10, 64'h0, 64'h0, 0), "abort_rd", 0, rd, er, lat);
    chk("abort_rd_lat", 64'(lat), 64'd2);
    chk("abort_rd_rdata", rd, 64'hCAFE_F00D_AAAA_5555);
    chk("abort_rd_err", 64'(er), 64'd0);
    lat_pair(1, 64'h40, 64'h4444_1111_8888_2222, l1, l4, r1, r4, n1, n4);
    chk("l1_wr_lat", 64'(l1), 64'd1);
    chk("l4_wr_lat", 64'(l4), 64'd4);
    chk("l1_wr_pulses", 64'(n1), 64'd1);
    chk("l4_wr_pulses", 64'(n4), 64'd1);
    lat_pair(0, 64'h40, 64'h0, l1, l4, r1, r4, n1, n4);
    chk("l1_rd_lat", 64'(l1), 64'd1);
    chk("l4_rd_lat", 64'(l4), 64'd4);
    chk("l1_rd_rdata", r1, 64'h4444_1111_8888_2222);
    chk("l4_rd_rdata", r4, 64'h4444_1111_8888_2222);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
